// File: rtl/bin2csd_pkg.sv
// Shared definitions for the bin2csd digit scheduler: CSD digit codes and FSM states.
package bin2csd_pkg;

    localparam logic [1:0] CSD_0  = 2'b00;
    localparam logic [1:0] CSD_P1 = 2'b01;
    localparam logic [1:0] CSD_M1 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

endpackage

// File: rtl/bin2csd.sv
// Combinational two's-complement to canonical-signed-digit converter.
// Digit i of the W-digit result sits at y[2i+1:2i].
module bin2csd
    import bin2csd_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0]   x,
    output logic [2*W-1:0] y
);

    logic [W:0] xe;
    logic       c;

    // Sign extension makes the final carry equal the sign bit, so W digits are exact.
    assign xe = {x[W-1], x};

    always_comb begin
        y = '0;
        c = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (xe[i] ^ c) begin
                if (xe[i+1]) begin
                    y[2*i +: 2] = CSD_M1;
                    c           = 1'b1;
                end else begin
                    y[2*i +: 2] = CSD_P1;
                    c           = 1'b0;
                end
            end else begin
                y[2*i +: 2] = CSD_0;
                c           = xe[i];
            end
        end
    end

endmodule

// File: rtl/bin2csd_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or above ptr, wrapping.
module bin2csd_rr_arb #(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bin2csd_sched.sv
// Shares one bin2csd converter among N_REQ requesters and streams each word's
// CSD digits MSB-first with a valid/ready handshake, tagged by source index.
module bin2csd_sched
    import bin2csd_pkg::*;
#(
    parameter int unsigned W     = 5,
    parameter int unsigned N_REQ = 2,
    parameter int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_x,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [1:0]           dig,
    output logic                 dig_last,
    output logic [SRC_W-1:0]     dig_src,
    output logic                 busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    state_t           state, state_nx;
    logic [W-1:0]     x_q;
    logic [SRC_W-1:0] src_q;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] gnt_idx;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   sh;
    logic [2*W-1:0]   y;
    logic [N_REQ-1:0] gnt;
    logic             arb_en;
    logic             take;

    // Gating with rst keeps a grant from being offered in a cycle that reset wins.
    assign arb_en    = (state == ST_IDLE) && !rst;
    assign req_ready = gnt;
    assign take      = |(gnt & req_valid);

    bin2csd_rr_arb #(.N(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (gnt)
    );

    bin2csd #(.W(W)) u_csd (
        .x (x_q),
        .y (y)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_idx = SRC_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (take) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_SEND;
            ST_SEND: if (dig_ready && cnt == '0) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        dig_valid = (state == ST_SEND);
        busy      = (state != ST_IDLE);
        dig       = dig_valid ? sh[2*cnt +: 2] : CSD_0;
        dig_last  = dig_valid && (cnt == '0);
        dig_src   = src_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            src_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
            sh    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (take) begin
                    x_q   <= req_x[32'(gnt_idx)*W +: W];
                    src_q <= gnt_idx;
                    ptr   <= (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                end
                ST_LOAD: begin
                    sh  <= y;
                    cnt <= CW'(W - 1);
                end
                ST_SEND: if (dig_ready && cnt != '0) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
